dac_stream_out: RTL and testbench
=================================

Name: dac_stream_out

Overview:
- Transmit-side counterpart of the ADC sample extractor. Takes processed 14-bit samples (e.g. wavelet reconstruction output) with a valid strobe and drives an AXI4-Stream master into the DAC interface.
- Buffers samples in a small FIFO so brief tready deassertion loses nothing.
- Packs each sample into the 32-bit DAC word, with optional duplication to channel B.
- Reports overflow and FIFO fill level for debug/ILA.

Parameters:
- DAC_WIDTH, 14, sample width in bits.
- AXIS_TDATA_WIDTH, 32, output stream width; two 16-bit lanes.
- FIFO_ADDR_WIDTH, 4, FIFO depth = 2**FIFO_ADDR_WIDTH (16 entries).
- DUAL_CHANNEL, 1, 1 = sample copied to lane B; 0 = lane B driven with zero.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- dac_data_in  input  DAC_WIDTH  two's-complement sample.
- dac_data_valid  input  1  single-cycle strobe; dac_data_in is valid this cycle.
- M_AXIS_OUT_tdata  output  AXIS_TDATA_WIDTH  packed DAC word.
- M_AXIS_OUT_tvalid  output  1  AXIS valid.
- M_AXIS_OUT_tready  input  1  AXIS ready from the DAC side.
- fifo_level  output  FIFO_ADDR_WIDTH+1  current FIFO occupancy, 0..2**FIFO_ADDR_WIDTH.
- overflow  output  1  sticky flag: at least one sample dropped.

Behaviour:
- Reset (rst=1 at a clk edge): FIFO pointers and count = 0, M_AXIS_OUT_tvalid=0, M_AXIS_OUT_tdata=0, fifo_level=0, overflow=0. Reset overrides all other activity, including mid-transfer. Buffered samples are discarded.
- Write path:
  - On dac_data_valid=1 with registered count < depth, the sample is written and count increments.
  - On dac_data_valid=1 with count == depth (full), the sample is dropped and overflow is set to 1. overflow holds until rst.
  - Full is evaluated on the registered count. A write is refused when full even if a pop occurs in the same cycle.
- Output register: single registered stage feeding the AXIS outputs.
  - Load condition: FIFO not empty AND (tvalid==0 OR tready==1).
  - On load: pop the FIFO head, set tvalid=1, set tdata to the packed head.
  - If tvalid==1, tready==1 and the FIFO is empty: tvalid falls to 0 and tdata holds its last value.
  - If tvalid==1 and tready==0: tdata and tvalid stay stable (AXIS rule). No pop occurs.
- Simultaneous push and pop: count unchanged, both complete.
- No bypass: a sample written into an empty FIFO at edge N is loaded at edge N+1. tvalid is high from N+1, so latency is 2 clk edges from strobe to tvalid.
- Sustained throughput: 1 word/clk when tready is held high.
- Packing, lane k at bits [16k+15:16k]:
  - Lane A = sign-extended dac_data_in to 16 bits ({2{sample[13]}}, sample).
  - Lane B = the same value if DUAL_CHANNEL=1, else 16'h0000.
  - Bits above 32 (if AXIS_TDATA_WIDTH > 32) are zero.
- Pointers wrap modulo depth. Count is FIFO_ADDR_WIDTH+1 bits so full and empty are distinguished.
- fifo_level = registered count (excludes the word held in the output register).

Decomposition:
- Shared package/header: DAC_WIDTH=14, AXIS_TDATA_WIDTH=32, lane width 16, lane offsets 0/16, and the sign-extension width constant. ADC and DAC blocks share these constants.
- One sub-module: sync_fifo (parameters WIDTH and ADDR_WIDTH). Single clock, synchronous reset, with push/pop/full/empty/count. Packing and output register stay in dac_stream_out.

Test Plan:
- Reset then idle: rst high 3 cycles → tvalid=0, tdata=0, fifo_level=0, overflow=0. Stays so with no strobes.
- Single sample: tready=1, strobe 14'h1FFF at edge N → tvalid=1 from N+1 to N+2 with tdata=32'h1FFF1FFF, then tvalid=0. With DUAL_CHANNEL=0 → 32'h00001FFF. Negative input 14'h2000 → 32'hE000E000.
- Backpressure: tready=0, strobe 5 samples 1..5 → fifo_level reaches 4 and tdata stays 32'h00010001 throughout. Release tready → words 1..5 out in order on consecutive cycles, no gaps.
- Overflow: tready=0, strobe 20 consecutive samples (depth 16 + 1 output register) → 17 retained, overflow=1 from the first dropped sample on. Release tready → exactly samples 0..16 delivered, overflow stays 1 until rst.
- Streaming with random tready (50%), strobe every other cycle for 1000 samples → all received in order, none lost, overflow=0.
- Reset mid-operation: fifo_level=8 and tvalid=1 with tready=0, assert rst 1 cycle → next cycle tvalid=0, fifo_level=0, overflow=0. Subsequent samples come out with no stale data.

Source files
------------

// File: rtl/dac_stream_out_pkg.sv
// dac_stream_out_pkg
//   Constants shared by the ADC sample extractor and the DAC stream output:
//   sample width, AXIS word width, 16-bit lane geometry and the number of
//   sign bits needed to widen a sample to a full lane.
package dac_stream_out_pkg;

   localparam int DAC_SAMPLE_W = 14;                    // converter sample width
   localparam int AXIS_DATA_W  = 32;                    // stream word width
   localparam int LANE_W       = 16;                    // one channel lane
   localparam int LANE_A_LSB   = 0;                     // channel A offset
   localparam int LANE_B_LSB   = 16;                    // channel B offset
   localparam int SEXT_W       = LANE_W - DAC_SAMPLE_W; // sign bits added per lane

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with synchronous active-high reset.
//   Ports:
//     i_clk, i_rst      clock, synchronous reset (clears pointers and count)
//     i_push, i_data    write request and data; ignored when full
//     i_pop             read request; ignored when empty
//     o_data            current head (valid when !o_empty)
//     o_full, o_empty   status derived from the registered count
//     o_count           occupancy 0..2**ADDR_WIDTH
module sync_fifo #(
   parameter int WIDTH      = 14,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_push,
   input  logic [WIDTH-1:0]      i_data,
   input  logic                  i_pop,
   output logic [WIDTH-1:0]      o_data,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [ADDR_WIDTH:0]   o_count
);

   localparam int                    DEPTH    = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
   localparam logic [ADDR_WIDTH:0]   CNT_FULL = DEPTH[ADDR_WIDTH:0];

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wptr;
   logic [ADDR_WIDTH-1:0] r_rptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  w_do_push;
   logic                  w_do_pop;

   // Full/empty come from the registered count only, so a write is refused
   // while full even if a pop frees a slot on the same edge.
   assign o_full    = (r_count == CNT_FULL);
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop  && !o_empty;
   assign o_data    = r_mem[r_rptr];
   assign o_count   = r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
         if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset; the pointers define what is live.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_data;
   end

endmodule

// File: rtl/dac_stream_out.sv
// dac_stream_out
//   Buffers strobed DAC samples in a FIFO and drives them out as an AXI4-Stream
//   master, one sample per word, sign-extended into lane A and optionally
//   copied into lane B.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     dac_data_in          two's-complement sample
//     dac_data_valid       single-cycle sample strobe
//     M_AXIS_OUT_tdata     packed DAC word (registered)
//     M_AXIS_OUT_tvalid    AXIS valid (registered)
//     M_AXIS_OUT_tready    AXIS ready from the DAC
//     fifo_level           FIFO occupancy, not counting the output register
//     overflow             sticky: a sample was dropped because the FIFO was full
module dac_stream_out
   import dac_stream_out_pkg::*;
#(
   parameter int DAC_WIDTH        = DAC_SAMPLE_W,
   parameter int AXIS_TDATA_WIDTH = AXIS_DATA_W,
   parameter int FIFO_ADDR_WIDTH  = 4,
   parameter int DUAL_CHANNEL     = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DAC_WIDTH-1:0]        dac_data_in,
   input  logic                        dac_data_valid,
   output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_OUT_tdata,
   output logic                        M_AXIS_OUT_tvalid,
   input  logic                        M_AXIS_OUT_tready,
   output logic [FIFO_ADDR_WIDTH:0]    fifo_level,
   output logic                        overflow
);

   logic [DAC_WIDTH-1:0]        w_head;
   logic                        w_full;
   logic                        w_empty;
   logic [FIFO_ADDR_WIDTH:0]    w_count;
   logic                        w_load;
   logic [LANE_W-1:0]           w_lane;
   logic [AXIS_TDATA_WIDTH-1:0] w_packed;

   logic [AXIS_TDATA_WIDTH-1:0] r_tdata;
   logic                        r_tvalid;
   logic                        r_overflow;

   // The output register refills whenever it is empty or being drained.
   assign w_load = !w_empty && (!r_tvalid || M_AXIS_OUT_tready);

   sync_fifo #(
      .WIDTH      (DAC_WIDTH),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_push  (dac_data_valid),
      .i_data  (dac_data_in),
      .i_pop   (w_load),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Samples are packed on the way out so the FIFO only stores DAC_WIDTH bits.
   assign w_lane = LANE_W'($signed(w_head));

   always_comb begin
      w_packed = '0;
      w_packed[LANE_A_LSB +: LANE_W] = w_lane;
      if (DUAL_CHANNEL != 0) w_packed[LANE_B_LSB +: LANE_W] = w_lane;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tdata    <= '0;
         r_tvalid   <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_load) begin
            r_tdata  <= w_packed;
            r_tvalid <= 1'b1;
         end else if (r_tvalid && M_AXIS_OUT_tready) begin
            // Drained with nothing behind it; tdata keeps its last value.
            r_tvalid <= 1'b0;
         end
         if (dac_data_valid && w_full) r_overflow <= 1'b1;
      end
   end

   assign M_AXIS_OUT_tdata  = r_tdata;
   assign M_AXIS_OUT_tvalid = r_tvalid;
   assign fifo_level        = w_count;
   assign overflow          = r_overflow;

endmodule

// File: tb/tb_dac_stream_out.sv
module tb_dac_stream_out;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] din;
   logic        dvalid;
   logic        tready;

   logic [31:0] tdata,  tdata0;
   logic        tvalid, tvalid0;
   logic [4:0]  level,  level0;
   logic        ovf,    ovf0;

   always #5 clk = ~clk;

   dac_stream_out #(.DUAL_CHANNEL(1)) dut (
      .clk(clk), .rst(rst), .dac_data_in(din), .dac_data_valid(dvalid),
      .M_AXIS_OUT_tdata(tdata), .M_AXIS_OUT_tvalid(tvalid),
      .M_AXIS_OUT_tready(tready), .fifo_level(level), .overflow(ovf));

   dac_stream_out #(.DUAL_CHANNEL(0)) dut0 (
      .clk(clk), .rst(rst), .dac_data_in(din), .dac_data_valid(dvalid),
      .M_AXIS_OUT_tdata(tdata0), .M_AXIS_OUT_tvalid(tvalid0),
      .M_AXIS_OUT_tready(tready), .fifo_level(level0), .overflow(ovf0));

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Receiver: a word is taken at the rising edge after a negedge where
   // tvalid && tready are both high.
   logic [31:0] rxq[$];
   int          rxcyc[$];
   int          cyc = 0;
   always @(negedge clk) begin
      cyc++;
      if (tvalid && tready) begin
         rxq.push_back(tdata);
         rxcyc.push_back(cyc);
      end
   end

   function automatic logic [31:0] pack_dual(input logic [13:0] s);
      logic [15:0] l;
      l = {{2{s[13]}}, s};
      return {l, l};
   endfunction

   typedef struct {
      logic [13:0] sample;
      logic [31:0] exp_dual;
      logic [31:0] exp_single;
   } vec_t;

   vec_t vecs[5];
   logic [31:0] expq[$];

   initial begin
      vecs[0] = '{14'h1FFF, 32'h1FFF1FFF, 32'h00001FFF};
      vecs[1] = '{14'h2000, 32'hE000E000, 32'h0000E000};
      vecs[2] = '{14'h0000, 32'h00000000, 32'h00000000};
      vecs[3] = '{14'h3FFF, 32'hFFFFFFFF, 32'h0000FFFF};
      vecs[4] = '{14'h0ABC, 32'h0ABC0ABC, 32'h00000ABC};

      rst = 1'b1; din = '0; dvalid = 1'b0; tready = 1'b1;

      // Reset then idle
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
      chk("rst_tdata", tdata, 32'd0);
      chk("rst_level", {27'd0, level}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      repeat (5) tick();
      chk("idle_tvalid", {31'd0, tvalid}, 32'd0);
      chk("idle_level", {27'd0, level}, 32'd0);

      // Single samples: packing and 2-edge latency, both lane-B modes
      for (int i = 0; i < 5; i++) begin
         din = vecs[i].sample; dvalid = 1'b1;
         tick();
         dvalid = 1'b0;
         chk("lat_n_tvalid", {31'd0, tvalid}, 32'd0);
         tick();
         chk("lat_n1_tvalid", {31'd0, tvalid}, 32'd1);
         chk("pack_dual", tdata, vecs[i].exp_dual);
         chk("pack_single", tdata0, vecs[i].exp_single);
         tick();
         chk("drain_tvalid", {31'd0, tvalid}, 32'd0);
         chk("drain_hold", tdata, vecs[i].exp_dual);
      end

      // Backpressure: 5 samples with tready low, then release
      tready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         din = 14'(i); dvalid = 1'b1;
         tick();
         if (i >= 2) chk("bp_tdata_stable", tdata, 32'h00010001);
      end
      dvalid = 1'b0;
      chk("bp_level", {27'd0, level}, 32'd4);
      repeat (3) tick();
      chk("bp_tdata_hold", tdata, 32'h00010001);
      chk("bp_tvalid_hold", {31'd0, tvalid}, 32'd1);
      rxq.delete(); rxcyc.delete();
      tready = 1'b1;
      repeat (7) tick();
      chk("bp_count", rxq.size(), 32'd5);
      for (int i = 0; i < rxq.size() && i < 5; i++) begin
         chk("bp_word", rxq[i], {16'(i + 1), 16'(i + 1)});
         if (i > 0) chk("bp_no_gap", rxcyc[i] - rxcyc[i-1], 32'd1);
      end

      // Overflow: 20 samples into depth 16 + output register
      tready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         din = 14'(i); dvalid = 1'b1;
         tick();
         if (i == 16) begin
            chk("ovf_not_yet", {31'd0, ovf}, 32'd0);
            chk("ovf_full_level", {27'd0, level}, 32'd16);
         end
         if (i == 17) chk("ovf_set", {31'd0, ovf}, 32'd1);
      end
      dvalid = 1'b0;
      chk("ovf_level", {27'd0, level}, 32'd16);
      rxq.delete(); rxcyc.delete();
      tready = 1'b1;
      repeat (25) tick();
      chk("ovf_count", rxq.size(), 32'd17);
      for (int i = 0; i < rxq.size() && i < 17; i++)
         chk("ovf_word", rxq[i], {16'(i), 16'(i)});
      chk("ovf_sticky", {31'd0, ovf}, 32'd1);
      chk("ovf_drained", {27'd0, level}, 32'd0);

      // Reset mid-operation (overflow still set from above)
      tready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         din = 14'(100 + i); dvalid = 1'b1;
         tick();
      end
      dvalid = 1'b0;
      chk("mid_level", {27'd0, level}, 32'd8);
      chk("mid_tvalid", {31'd0, tvalid}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_tvalid", {31'd0, tvalid}, 32'd0);
      chk("mid_rst_level", {27'd0, level}, 32'd0);
      chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
      chk("mid_rst_tdata", tdata, 32'd0);
      rxq.delete(); rxcyc.delete();
      tready = 1'b1;
      din = 14'h0ABC; dvalid = 1'b1;
      tick();
      dvalid = 1'b0;
      repeat (4) tick();
      chk("mid_post_count", rxq.size(), 32'd1);
      if (rxq.size() > 0) chk("mid_post_word", rxq[0], 32'h0ABC0ABC);

      // Streaming: strobe every other cycle, random tready. tready is forced
      // high near full so the random walk never reaches the drop point.
      rxq.delete(); rxcyc.delete(); expq.delete();
      for (int c = 0; c < 2000; c++) begin
         dvalid = (c % 2 == 0);
         din    = 14'($urandom);
         if (dvalid) expq.push_back(pack_dual(din));
         tready = ($urandom_range(0, 1) == 1) || (level >= 5'd12);
         tick();
      end
      dvalid = 1'b0;
      tready = 1'b1;
      repeat (40) tick();
      chk("stream_count", rxq.size(), expq.size());
      for (int i = 0; i < rxq.size() && i < expq.size(); i++)
         chk("stream_word", rxq[i], expq[i]);
      chk("stream_ovf", {31'd0, ovf}, 32'd0);
      chk("stream_tvalid_idle", {31'd0, tvalid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
